// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle logic/arith ops
// and an iterative shift-add multiplier; registered result/flags.
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter bit ACC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               acc_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    prod;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x;
  logic             take_in;
  logic             take_out;
  logic             mul_last;
  logic             load;
  logic [RW-1:0]    prod_nxt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [RW-1:0]    alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [RW-1:0]    res_d;
  logic [3:0]       flg_d;

  assign x        = (ACC_EN && acc_sel) ? acc : a;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign take_in  = in_valid && in_ready;
  assign take_out = out_valid && out_ready;
  assign busy     = (state == MUL);
  assign mul_last = (state == MUL) && (cnt == CW'(WIDTH - 1));
  assign load     = (take_in && (opcode != OP_MUL)) || mul_last;

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  assign sum  = {1'b0, x} + {1'b0, b};
  assign diff = {1'b0, x} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_res = RW'(sum);
        alu_c   = sum[WIDTH];
        alu_v   = (x[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // bit WIDTH of the widened difference is the borrow
        alu_res = RW'(diff);
        alu_c   = diff[WIDTH];
        alu_v   = (x[WIDTH-1] != b[WIDTH-1]) &&
                  (diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: alu_res = RW'(x & b);
      OP_OR:  alu_res = RW'(x | b);
      OP_XOR: alu_res = RW'(x ^ b);
      OP_SHL: begin
        alu_res = RW'(x) << b[SW-1:0];
        alu_c   = |alu_res[RW-1:WIDTH];
      end
      OP_CLR: alu_res = ACC_EN ? RW'(acc) : '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_d = alu_res;
    flg_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
    if (state == MUL) begin
      res_d = prod_nxt;
      flg_d = {1'b0, prod_nxt == '0,
               |prod_nxt[RW-1:WIDTH], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_in && (opcode == OP_MUL)) begin
            state  <= MUL;
            mcand  <= RW'(x);
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        result    <= res_d;
        flags     <= flg_d;
        out_valid <= 1'b1;
        if ((state == IDLE) && (opcode == OP_CLR))
          acc <= '0;
        else
          acc <= res_d[WIDTH-1:0];
      end else if (take_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand sequences for
// multiply timing, output backpressure and mid-multiply reset.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] CLR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [2:0] opcode;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(4), .ACC_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] va;
    logic [3:0] vb;
    logic       sel;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [3:0] va, input logic [3:0] vb,
                       input logic sel);
    in_valid = v;
    opcode   = op;
    op_a     = va;
    op_b     = vb;
    acc_sel  = sel;
  endtask

  initial begin
    // flags are {N,Z,C,V}
    vt[0]  = '{"add_ff",   ADD, 4'hF, 4'hF, 1'b0, 8'h1E, 4'b1010};
    vt[1]  = '{"sub_4_d",  SUB, 4'h4, 4'hD, 1'b0, 8'h17, 4'b0010};
    vt[2]  = '{"and_4_d",  AND, 4'h4, 4'hD, 1'b0, 8'h04, 4'b0000};
    vt[3]  = '{"or_4_d",   OR,  4'h4, 4'hD, 1'b0, 8'h0D, 4'b1000};
    vt[4]  = '{"xor_4_d",  XOR, 4'h4, 4'hD, 1'b0, 8'h09, 4'b1000};
    vt[5]  = '{"add_5_3",  ADD, 4'h5, 4'h3, 1'b0, 8'h08, 4'b1001};
    vt[6]  = '{"acc_add2", ADD, 4'hF, 4'h2, 1'b1, 8'h0A, 4'b1000};
    vt[7]  = '{"clr",      CLR, 4'h0, 4'h0, 1'b0, 8'h0A, 4'b1000};
    vt[8]  = '{"acc_add0", ADD, 4'h7, 4'h0, 1'b1, 8'h00, 4'b0100};
    vt[9]  = '{"shl_3_3",  SHL, 4'h3, 4'h3, 1'b0, 8'h18, 4'b1010};
    vt[10] = '{"shl_f_6",  SHL, 4'hF, 4'h6, 1'b0, 8'h3C, 4'b1010};
    vt[11] = '{"sub_9_3",  SUB, 4'h9, 4'h3, 1'b0, 8'h06, 4'b0001};
    vt[12] = '{"sub_5_5",  SUB, 4'h5, 4'h5, 1'b0, 8'h00, 4'b0100};
    vt[13] = '{"add_7_1",  ADD, 4'h7, 4'h1, 1'b0, 8'h08, 4'b1001};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, ADD, 4'h0, 4'h0, 1'b0);
    step();
    step();
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vt[i].op, vt[i].va, vt[i].vb, vt[i].sel);
      step();
      chk({vt[i].name, "_res"}, 32'(result), 32'(vt[i].res));
      chk({vt[i].name, "_flg"}, 32'(flags), 32'(vt[i].flg));
      chk({vt[i].name, "_ov"}, 32'(out_valid), 32'h1);
    end

    // multiply: junk ADD stays offered while busy
    drive(1'b1, MUL, 4'hF, 4'hF, 1'b0);
    step();
    drive(1'b1, ADD, 4'h1, 4'h1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mul_busy%0d", c), 32'(busy), 32'h1);
      chk($sformatf("mul_rdy%0d", c), 32'(in_ready), 32'h0);
      chk($sformatf("mul_ov%0d", c), 32'(out_valid), 32'h0);
      step();
    end
    chk("mul_res", 32'(result), 32'hE1);
    chk("mul_flg", 32'(flags), 32'b0010);
    chk("mul_ov", 32'(out_valid), 32'h1);
    chk("mul_busy_end", 32'(busy), 32'h0);
    drive(1'b0, ADD, 4'h0, 4'h0, 1'b0);
    step();
    chk("mul_drain", 32'(out_valid), 32'h0);

    // backpressure then simultaneous in/out transfer
    out_ready = 1'b0;
    drive(1'b1, ADD, 4'h3, 4'h4, 1'b0);
    step();
    chk("hold_res0", 32'(result), 32'h07);
    drive(1'b1, ADD, 4'h1, 4'h2, 1'b0);
    #1;
    chk("hold_rdy", 32'(in_ready), 32'h0);
    step();
    step();
    chk("hold_res2", 32'(result), 32'h07);
    chk("hold_ov", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("both_rdy", 32'(in_ready), 32'h1);
    step();
    chk("both_res", 32'(result), 32'h03);
    chk("both_ov", 32'(out_valid), 32'h1);
    drive(1'b0, ADD, 4'h0, 4'h0, 1'b0);
    step();
    chk("both_drain", 32'(out_valid), 32'h0);

    // reset in the second multiply cycle
    drive(1'b1, MUL, 4'hF, 4'hF, 1'b0);
    step();
    drive(1'b0, ADD, 4'h0, 4'h0, 1'b0);
    step();
    chk("mrst_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_result", 32'(result), 32'h00);
    chk("mrst_flags", 32'(flags), 32'h0);
    chk("mrst_ov", 32'(out_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst_rdy", 32'(in_ready), 32'h1);
    drive(1'b1, ADD, 4'h1, 4'h1, 1'b0);
    step();
    chk("post_add", 32'(result), 32'h02);
    chk("post_add_flg", 32'(flags), 32'h0);
    step();
    drive(1'b1, ADD, 4'h9, 4'h0, 1'b1);
    step();
    chk("post_acc", 32'(result), 32'h02);
    drive(1'b0, ADD, 4'h0, 4'h0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (>=2).
REQ-002 SHALL have parameter ACC_EN, default 1, enables the accumulator operand and CLR opcode (0: acc_sel ignored, CLR returns 0).
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a, b  input  WIDTH each  unsigned operands.
REQ-008 opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 CLR.
REQ-009 acc_sel  input  1  1: use the accumulator in place of a.
REQ-010 out_valid  output  1  result register holds an untaken result.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  2*WIDTH  registered result.
REQ-013 flags  output  4  {N,Z,C,V}, registered with result.
REQ-014 busy  output  1  high while in MUL state.

Function
REQ-015 Transfer-in SHALL occur on a rising edge with in_valid && in_ready; transfer-out on a rising edge with out_valid && out_ready.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinational.
REQ-017 States SHALL be IDLE and MUL; IDLE->MUL on transfer-in of MUL; MUL->IDLE after exactly WIDTH cycles in MUL; all other opcodes stay in IDLE.
REQ-018 Non-MUL ops SHALL load result/flags and set out_valid on the transfer-in edge (latency 1).
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per cycle; result/flags load and out_valid sets on the WIDTH-th MUL edge; no input accepted meanwhile.
REQ-020 out_valid SHALL clear on transfer-out unless a new result loads on the same edge, in which case it stays high; result/flags SHALL hold stable while out_valid && !out_ready.
REQ-021 Operand x SHALL be acc when ACC_EN && acc_sel, else a; operands latched on transfer-in.
REQ-022 ADD: result[WIDTH:0] = x+b, upper bits 0; C = carry-out; V = signed overflow.
REQ-023 SUB: result[WIDTH-1:0] = x-b mod 2^WIDTH, result[WIDTH] = borrow (x<b), upper bits 0; C = borrow; V = signed overflow.
REQ-024 AND/OR/XOR: bitwise on low WIDTH bits, upper 0; C=V=0.
REQ-025 SHL: result = zero-extended x << b[clog2(WIDTH)-1:0]; C = |result[2W-1:W]; V=0.
REQ-026 MUL: unsigned x*b, full 2*WIDTH bits; C = |result[2W-1:W]; V=0; N=0.
REQ-027 CLR: result = zero-extended acc, then acc <= 0; C=V=0.
REQ-028 Z SHALL be 1 iff result==0 (full width); N SHALL be result[WIDTH-1] except MUL.
REQ-029 Accumulator (WIDTH bits) SHALL load result[WIDTH-1:0] whenever result loads, except CLR (clears).
REQ-030 opcode/operand changes while in_ready=0 SHALL have no effect.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, acc=0, result=0, flags=0, out_valid=0, busy=0, discarding any in-progress MUL.
REQ-032 After rst_n rises, in_ready SHALL be 1 in the same cycle; first transfer-in possible on the next edge.

Verification (WIDTH=4)
REQ-033 ADD a=1111 b=1111 -> result=0x1E one edge later, flags N=1 Z=0 C=1 V=0.
REQ-034 SUB a=0100 b=1101 -> result=0x17, C=1, V=0, N=0; then AND/OR/XOR same operands -> 0x04, 0x0D, 0x09.
REQ-035 MUL a=1111 b=1111 -> busy high 4 cycles, in_ready 0, out_valid on 4th edge, result=0xE1, C=1, Z=0.
REQ-036 Hold out_ready=0 after ADD 3+4 -> result 0x07 held, in_ready 0; raise out_ready with new ADD queued -> both transfers on one edge, out_valid stays 1.
REQ-037 Accumulate: ADD 5+3, then acc_sel=1 ADD b=2 -> 0x0A; CLR -> 0x0A, next acc_sel ADD b=0 -> 0x00, Z=1.
REQ-038 Assert rst_n low mid-MUL (2nd cycle) -> all outputs 0, state IDLE; subsequent ADD 1+1 -> 0x02.
